// File: rtl/sd_cmd_sched.sv
// SD CMD-line issue scheduler: NCC gap, PHY issue, response window, retry and done/fail report.
// Optional cumulative retry statistics are enabled by defining SD_CMD_STATS_EN.
module sd_cmd_sched #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 1024,
  parameter int unsigned GAP       = 8
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [5:0]  iindex,
  input  logic [31:0] iarg,
  output logic        ostart_phy,
  output logic [5:0]  oindex,
  output logic [31:0] oarg,
  input  logic        iphy_tx_done,
  input  logic        iphy_done,
  input  logic        iphy_crc_fail,
  input  logic [31:0] iphy_resp,
  output logic        obusy,
  output logic        odone,
  output logic        ofail,
  output logic [31:0] oresp,
  output logic [1:0]  oattempt,
  output logic [15:0] ostat_retries
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLast = GW'(GAP - 1);

  typedef enum logic [1:0] {StIdle, StGap, StIssue, StWait} state_e;

  state_e        state_q;
  logic [GW-1:0] gap_cnt_q;
  logic [TW-1:0] tout_cnt_q;

  logic no_resp, no_crc, rsp_good, rsp_bad, tout_hit, win, lose, can_retry;

  always_comb begin
    no_resp   = (oindex == 6'd0) || (oindex == 6'd4) || (oindex == 6'd15);
    // R3 carries no valid CRC7, so the PHY's CRC verdict is meaningless for it
    no_crc    = (oindex == 6'd41);
    rsp_good  = iphy_done && (!iphy_crc_fail || no_crc);
    rsp_bad   = iphy_done && iphy_crc_fail && !no_crc;
    tout_hit  = (tout_cnt_q == TLast);
    win       = (state_q == StWait) && (no_resp ? iphy_tx_done : rsp_good);
    // A good response in the terminal-count cycle still wins over the timeout
    lose      = (state_q == StWait) && !no_resp && !rsp_good && (rsp_bad || tout_hit);
    can_retry = 32'(oattempt) < MAX_RETRY;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q    <= StIdle;
      gap_cnt_q  <= '0;
      tout_cnt_q <= '0;
      ostart_phy <= 1'b0;
      oindex     <= '0;
      oarg       <= '0;
      obusy      <= 1'b0;
      odone      <= 1'b0;
      ofail      <= 1'b0;
      oresp      <= '0;
      oattempt   <= '0;
    end else begin
      ostart_phy <= 1'b0;
      odone      <= 1'b0;
      ofail      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A request coinciding with the completion pulse is dropped
          if (istart && !odone && !ofail) begin
            state_q   <= StGap;
            gap_cnt_q <= GLast;
            oindex    <= iindex;
            oarg      <= iarg;
            obusy     <= 1'b1;
            oattempt  <= '0;
          end
        end
        StGap: begin
          if (gap_cnt_q == '0) begin
            state_q    <= StIssue;
            ostart_phy <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end
        StIssue: begin
          state_q    <= StWait;
          tout_cnt_q <= '0;
        end
        StWait: begin
          if (win) begin
            odone   <= 1'b1;
            obusy   <= 1'b0;
            state_q <= StIdle;
            if (!no_resp) oresp <= iphy_resp;
          end else if (lose) begin
            if (can_retry) begin
              oattempt  <= (oattempt == 2'b11) ? oattempt : oattempt + 2'd1;
              gap_cnt_q <= GLast;
              state_q   <= StGap;
            end else begin
              ofail   <= 1'b1;
              obusy   <= 1'b0;
              state_q <= StIdle;
            end
          end else if (!no_resp) begin
            tout_cnt_q <= tout_cnt_q + TW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SD_CMD_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge iclk) begin
    if (irst) begin
      stat_q <= '0;
    end else if (lose && can_retry && (stat_q != 16'hFFFF)) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign ostat_retries = stat_q;
`else
  assign ostat_retries = '0;
`endif

endmodule

// File: tb/tb_sd_cmd_sched.sv
// Directed bench for sd_cmd_sched: vector table of whole commands plus hand-written corner sequences.
module tb_sd_cmd_sched;

  localparam int GAP       = 8;
  localparam int TIMEOUT   = 1024;
  localparam int MAX_RETRY = 3;

  localparam logic [1:0] C_NONE = 2'd0;  // PHY stays silent
  localparam logic [1:0] C_OK   = 2'd1;  // iphy_done, crc good
  localparam logic [1:0] C_BAD  = 2'd2;  // iphy_done, crc fail
  localparam logic [1:0] C_TX   = 2'd3;  // iphy_tx_done only

  logic        iclk = 1'b0;
  logic        irst;
  logic        istart;
  logic [5:0]  iindex;
  logic [31:0] iarg;
  logic        ostart_phy;
  logic [5:0]  oindex;
  logic [31:0] oarg;
  logic        iphy_tx_done;
  logic        iphy_done;
  logic        iphy_crc_fail;
  logic [31:0] iphy_resp;
  logic        obusy;
  logic        odone;
  logic        ofail;
  logic [31:0] oresp;
  logic [1:0]  oattempt;
  logic [15:0] ostat_retries;

  sd_cmd_sched #(
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT),
    .GAP       (GAP)
  ) dut (
    .iclk          (iclk),
    .irst          (irst),
    .istart        (istart),
    .iindex        (iindex),
    .iarg          (iarg),
    .ostart_phy    (ostart_phy),
    .oindex        (oindex),
    .oarg          (oarg),
    .iphy_tx_done  (iphy_tx_done),
    .iphy_done     (iphy_done),
    .iphy_crc_fail (iphy_crc_fail),
    .iphy_resp     (iphy_resp),
    .obusy         (obusy),
    .odone         (odone),
    .ofail         (ofail),
    .oresp         (oresp),
    .oattempt      (oattempt),
    .ostat_retries (ostat_retries)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [5:0]       idx;
    logic [31:0]      arg;
    logic [2:0]       n_att;
    logic [3:0][1:0]  code;      // per-attempt PHY behaviour, [0] first
    logic [7:0]       dly;       // final attempt: cycles from issue to PHY pulse
    logic [31:0]      rsp;       // final attempt payload
    logic             exp_done;
    logic [1:0]       exp_att;
    logic [31:0]      exp_resp;
    logic [2:0]       exp_issues;
  } vec_t;

  vec_t vecs[8];
  int   total = 0;
  int   bad = 0;
  int   stat_cum = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] stat_exp();
`ifdef SD_CMD_STATS_EN
    return 16'(stat_cum);
`else
    return 16'd0;
`endif
  endfunction

  task automatic pulse_phy(input logic [1:0] code, input logic [31:0] rsp);
    iphy_done     = (code == C_OK) || (code == C_BAD);
    iphy_crc_fail = (code == C_BAD);
    iphy_tx_done  = (code == C_TX);
    iphy_resp     = rsp;
    @(negedge iclk);
    iphy_done     = 1'b0;
    iphy_crc_fail = 1'b0;
    iphy_tx_done  = 1'b0;
    iphy_resp     = 32'h0;
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge iclk);
    istart = 1'b1;
    iindex = idx;
    iarg   = arg;
    @(negedge iclk);
    istart = 1'b0;
    iindex = ~idx;
    iarg   = ~arg;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int n;
    int issues;
    int dly;
    logic [1:0] code;
    logic [1:0] prev;
    logic [31:0] rsp;
    start_cmd(v.idx, v.arg);
    chk($sformatf("v%0d busy", id), 32'(obusy), 32'd1);
    n = 1;
    issues = 0;
    prev = C_OK;
    for (int a = 0; a < int'(v.n_att); a++) begin
      while (!ostart_phy && n < 3000) begin
        @(negedge iclk);
        n++;
      end
      if (!ostart_phy) begin
        chk($sformatf("v%0d issue_wait a%0d", id, a), 32'd0, 32'd1);
        return;
      end
      issues++;
      chk($sformatf("v%0d spacing a%0d", id, a), 32'(n),
          (prev == C_NONE) ? 32'(TIMEOUT + GAP + 1) : 32'(GAP + 1));
      chk($sformatf("v%0d oindex a%0d", id, a), 32'(oindex), 32'(v.idx));
      chk($sformatf("v%0d oarg a%0d", id, a), oarg, v.arg);
      code = v.code[a];
      dly  = (a == int'(v.n_att) - 1) ? int'(v.dly) : 10;
      rsp  = (a == int'(v.n_att) - 1) ? v.rsp : (32'hDEAD_0000 | 32'(a));
      if (code != C_NONE) begin
        repeat (dly) @(negedge iclk);
        pulse_phy(code, rsp);
      end else begin
        @(negedge iclk);
      end
      n = 1;
      prev = code;
    end
    while (!odone && !ofail && n < 3000) begin
      @(negedge iclk);
      n++;
    end
    chk($sformatf("v%0d latency", id), 32'(n), (prev == C_NONE) ? 32'(TIMEOUT + 1) : 32'd1);
    chk($sformatf("v%0d odone", id), 32'(odone), 32'(v.exp_done));
    chk($sformatf("v%0d ofail", id), 32'(ofail), 32'(!v.exp_done));
    chk($sformatf("v%0d obusy_end", id), 32'(obusy), 32'd0);
    chk($sformatf("v%0d oattempt", id), 32'(oattempt), 32'(v.exp_att));
    chk($sformatf("v%0d oresp", id), oresp, v.exp_resp);
    chk($sformatf("v%0d issues", id), 32'(issues), 32'(v.exp_issues));
    stat_cum += int'(v.exp_att);
    chk($sformatf("v%0d stat", id), 32'(ostat_retries), 32'(stat_exp()));
    @(negedge iclk);
    chk($sformatf("v%0d pulse_end", id), 32'({odone, ofail}), 32'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ostart_phy"}, 32'(ostart_phy), 32'd0);
    chk({nm, " obusy"}, 32'(obusy), 32'd0);
    chk({nm, " odone"}, 32'(odone), 32'd0);
    chk({nm, " ofail"}, 32'(ofail), 32'd0);
    chk({nm, " oindex"}, 32'(oindex), 32'd0);
    chk({nm, " oarg"}, oarg, 32'd0);
    chk({nm, " oresp"}, oresp, 32'd0);
    chk({nm, " oattempt"}, 32'(oattempt), 32'd0);
    chk({nm, " stat"}, 32'(ostat_retries), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    vecs[0] = '{6'd55, 32'h0000_FFFF, 3'd1, {C_NONE, C_NONE, C_NONE, C_OK}, 8'd20,
                32'h0000_0120, 1'b1, 2'd0, 32'h0000_0120, 3'd1};
    vecs[1] = '{6'd3, 32'h0000_0000, 3'd4, {C_NONE, C_NONE, C_NONE, C_NONE}, 8'd1,
                32'h0, 1'b0, 2'd3, 32'h0000_0120, 3'd4};
    vecs[2] = '{6'd2, 32'h0000_0000, 3'd3, {C_NONE, C_OK, C_BAD, C_BAD}, 8'd7,
                32'h1234_5678, 1'b1, 2'd2, 32'h1234_5678, 3'd3};
    vecs[3] = '{6'd41, 32'h40FF_8000, 3'd1, {C_NONE, C_NONE, C_NONE, C_BAD}, 8'd15,
                32'h8030_0000, 1'b1, 2'd0, 32'h8030_0000, 3'd1};
    vecs[4] = '{6'd15, 32'h0001_0000, 3'd1, {C_NONE, C_NONE, C_NONE, C_TX}, 8'd48,
                32'hFFFF_FFFF, 1'b1, 2'd0, 32'h8030_0000, 3'd1};
    vecs[5] = '{6'd8, 32'h0000_01AA, 3'd2, {C_NONE, C_NONE, C_OK, C_BAD}, 8'd3,
                32'h0000_01AA, 1'b1, 2'd1, 32'h0000_01AA, 3'd2};
    vecs[6] = '{6'd0, 32'h0000_0000, 3'd1, {C_NONE, C_NONE, C_NONE, C_TX}, 8'd1,
                32'h0BAD_0BAD, 1'b1, 2'd0, 32'h0000_01AA, 3'd1};
    vecs[7] = '{6'd17, 32'h0000_0200, 3'd4, {C_BAD, C_BAD, C_BAD, C_BAD}, 8'd2,
                32'h0000_0055, 1'b0, 2'd3, 32'h0000_01AA, 3'd4};

    irst = 1'b1;
    istart = 1'b0;
    iindex = '0;
    iarg = '0;
    iphy_tx_done = 1'b0;
    iphy_done = 1'b0;
    iphy_crc_fail = 1'b0;
    iphy_resp = '0;
    repeat (3) @(negedge iclk);
    chk_all_zero("reset");
    irst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // istart while busy is dropped; istart alongside odone is dropped
    start_cmd(6'd9, 32'h0000_A5A5);
    repeat (2) @(negedge iclk);
    istart = 1'b1;
    iindex = 6'd13;
    iarg = 32'h0;
    @(negedge iclk);
    istart = 1'b0;
    cnt = 0;
    while (!ostart_phy && cnt < 100) begin
      @(negedge iclk);
      cnt++;
    end
    chk("busy_ign oindex", 32'(oindex), 32'd9);
    chk("busy_ign oarg", oarg, 32'h0000_A5A5);
    repeat (4) @(negedge iclk);
    pulse_phy(C_OK, 32'h0000_CAFE);
    chk("busy_ign odone", 32'(odone), 32'd1);
    chk("busy_ign oresp", oresp, 32'h0000_CAFE);
    istart = 1'b1;
    iindex = 6'd13;
    @(negedge iclk);
    istart = 1'b0;
    chk("done_ign obusy", 32'(obusy), 32'd0);
    cnt = 0;
    repeat (GAP + 5) begin
      @(negedge iclk);
      if (ostart_phy || obusy) cnt++;
    end
    chk("done_ign activity", 32'(cnt), 32'd0);

    // good response exactly at the timeout terminal count
    start_cmd(6'd8, 32'h0000_01AB);
    n = 0;
    while (!ostart_phy && n < 100) begin
      @(negedge iclk);
      n++;
    end
    repeat (TIMEOUT) @(negedge iclk);
    chk("coinc no_early_fail", 32'(ofail), 32'd0);
    pulse_phy(C_OK, 32'h0000_01AB);
    chk("coinc odone", 32'(odone), 32'd1);
    chk("coinc ofail", 32'(ofail), 32'd0);
    chk("coinc oattempt", 32'(oattempt), 32'd0);
    chk("coinc oresp", oresp, 32'h0000_01AB);

    // reset while waiting for a response
    start_cmd(6'd3, 32'h1111_2222);
    n = 0;
    while (!ostart_phy && n < 100) begin
      @(negedge iclk);
      n++;
    end
    repeat (5) @(negedge iclk);
    irst = 1'b1;
    @(negedge iclk);
    irst = 1'b0;
    stat_cum = 0;
    chk_all_zero("midrst");
    cnt = 0;
    repeat (TIMEOUT + 2 * GAP + 10) begin
      @(negedge iclk);
      if (ostart_phy || odone || ofail || obusy) cnt++;
    end
    chk("midrst quiet", 32'(cnt), 32'd0);

    run_vec(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
